// File: rtl/alu2_issue_arb.sv
// Round-robin issue arbiter in front of the registered alu2, with tag tracking through the ALU latency
// and a credit-protected result FIFO so downstream back-pressure never loses a result.
module alu2_issue_arb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_ope,
    input  logic [31:0] req0_ds_val,
    input  logic [31:0] req0_dt_val,
    input  logic [5:0]  req0_dd,
    input  logic [15:0] req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_ope,
    input  logic [31:0] req1_ds_val,
    input  logic [31:0] req1_dt_val,
    input  logic [5:0]  req1_dd,
    input  logic [15:0] req1_imm,
    output logic [5:0]  alu_ope,
    output logic [31:0] alu_ds_val,
    output logic [31:0] alu_dt_val,
    output logic [5:0]  alu_dd,
    output logic [15:0] alu_imm,
    input  logic [5:0]  alu_reg_addr,
    input  logic [31:0] alu_reg_dd_val,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_src,
    output logic [5:0]  res_addr,
    output logic [31:0] res_val
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);
    localparam int EW = 1 + 6 + 32;

    logic          can_issue, grant0, grant1;
    logic [CW:0]   credit_sum;
    logic          rr_last_q, rr_last_d;
    logic [5:0]    alu_ope_q, alu_ope_d;
    logic [31:0]   alu_ds_q, alu_ds_d;
    logic [31:0]   alu_dt_q, alu_dt_d;
    logic [5:0]    alu_dd_q, alu_dd_d;
    logic [15:0]   alu_imm_q, alu_imm_d;
    logic          v_iss_q, v_iss_d, t_iss_q, t_iss_d;
    logic          v_alu_q, v_alu_d, t_alu_q, t_alu_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Credit counts every op already committed to a FIFO slot, so issue never overruns the FIFO.
    always_comb begin
        credit_sum = {1'b0, count_q} + (CW + 1)'(v_iss_q) + (CW + 1)'(v_alu_q);
        can_issue  = !rst && (credit_sum < DEPTH_L);
        grant0     = can_issue && req0_valid && (!req1_valid || rr_last_q);
        grant1     = can_issue && req1_valid && (!req0_valid || !rr_last_q);
    end

    always_comb begin
        alu_ope_d = '0;
        alu_ds_d  = alu_ds_q;
        alu_dt_d  = alu_dt_q;
        alu_dd_d  = alu_dd_q;
        alu_imm_d = alu_imm_q;
        rr_last_d = rr_last_q;
        if (grant0) begin
            alu_ope_d = req0_ope;
            alu_ds_d  = req0_ds_val;
            alu_dt_d  = req0_dt_val;
            alu_dd_d  = req0_dd;
            alu_imm_d = req0_imm;
            rr_last_d = 1'b0;
        end else if (grant1) begin
            alu_ope_d = req1_ope;
            alu_ds_d  = req1_ds_val;
            alu_dt_d  = req1_dt_val;
            alu_dd_d  = req1_dd;
            alu_imm_d = req1_imm;
            rr_last_d = 1'b1;
        end
        v_iss_d = grant0 || grant1;
        t_iss_d = grant1;
        v_alu_d = v_iss_q;
        t_alu_d = t_iss_q;
    end

    // Results are pushed unconditionally when tagged valid, including addr-0 results of illegal ops.
    always_comb begin
        push     = v_alu_q;
        pop      = (count_q != '0) && res_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {t_alu_q, alu_reg_addr, alu_reg_dd_val};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
            alu_ope_q <= '0;
            alu_ds_q  <= '0;
            alu_dt_q  <= '0;
            alu_dd_q  <= '0;
            alu_imm_q <= '0;
            v_iss_q   <= 1'b0;
            t_iss_q   <= 1'b0;
            v_alu_q   <= 1'b0;
            t_alu_q   <= 1'b0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            alu_ope_q <= alu_ope_d;
            alu_ds_q  <= alu_ds_d;
            alu_dt_q  <= alu_dt_d;
            alu_dd_q  <= alu_dd_d;
            alu_imm_q <= alu_imm_d;
            v_iss_q   <= v_iss_d;
            t_iss_q   <= t_iss_d;
            v_alu_q   <= v_alu_d;
            t_alu_q   <= t_alu_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_ope    = alu_ope_q;
    assign alu_ds_val = alu_ds_q;
    assign alu_dt_val = alu_dt_q;
    assign alu_dd     = alu_dd_q;
    assign alu_imm    = alu_imm_q;
    assign res_valid  = (count_q != '0);
    assign {res_src, res_addr, res_val} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_alu2_issue_arb.sv
// Directed bench for alu2_issue_arb: a small registered ALU stand-in, a vector table of single ops,
// and hand-written sequences for reset mid-stream, round-robin alternation and back-pressure.
module tb_alu2_issue_arb;

    localparam logic [5:0] OP_ADD  = 6'b001100;
    localparam logic [5:0] OP_SUB  = 6'b001110;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [5:0]  req0_ope = '0, req1_ope = '0;
    logic [31:0] req0_ds_val = '0, req1_ds_val = '0;
    logic [31:0] req0_dt_val = '0, req1_dt_val = '0;
    logic [5:0]  req0_dd = '0, req1_dd = '0;
    logic [15:0] req0_imm = '0, req1_imm = '0;
    logic [5:0]  alu_ope, alu_dd;
    logic [31:0] alu_ds_val, alu_dt_val;
    logic [15:0] alu_imm;
    logic [5:0]  alu_reg_addr;
    logic [31:0] alu_reg_dd_val;
    logic        res_valid, res_src;
    logic        res_ready = 1'b0;
    logic [5:0]  res_addr;
    logic [31:0] res_val;
    logic        alu_rstn;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu2_issue_arb #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ope(req0_ope),
        .req0_ds_val(req0_ds_val), .req0_dt_val(req0_dt_val), .req0_dd(req0_dd), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ope(req1_ope),
        .req1_ds_val(req1_ds_val), .req1_dt_val(req1_dt_val), .req1_dd(req1_dd), .req1_imm(req1_imm),
        .alu_ope(alu_ope), .alu_ds_val(alu_ds_val), .alu_dt_val(alu_dt_val),
        .alu_dd(alu_dd), .alu_imm(alu_imm),
        .alu_reg_addr(alu_reg_addr), .alu_reg_dd_val(alu_reg_dd_val),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_addr(res_addr), .res_val(res_val)
    );

    // Registered ALU stand-in; SRA shifts an unsigned operand, so it behaves as a logical shift.
    assign alu_rstn = ~rst;
    always_ff @(posedge clk or negedge alu_rstn) begin
        if (!alu_rstn) begin
            alu_reg_addr   <= '0;
            alu_reg_dd_val <= '0;
        end else begin
            case (alu_ope)
                OP_ADD:  begin alu_reg_addr <= alu_dd; alu_reg_dd_val <= alu_ds_val + alu_dt_val; end
                OP_SUB:  begin alu_reg_addr <= alu_dd; alu_reg_dd_val <= alu_ds_val - alu_dt_val; end
                OP_ADDI: begin alu_reg_addr <= alu_dd;
                               alu_reg_dd_val <= alu_ds_val + {{16{alu_imm[15]}}, alu_imm}; end
                OP_SRA:  begin alu_reg_addr <= alu_dd; alu_reg_dd_val <= alu_ds_val >>> alu_dt_val[4:0]; end
                OP_LUI:  begin alu_reg_addr <= alu_dd; alu_reg_dd_val <= {alu_imm, alu_ds_val[15:0]}; end
                default: begin alu_reg_addr <= '0; alu_reg_dd_val <= '0; end
            endcase
        end
    end

    typedef struct {
        logic        src;
        logic [5:0]  ope;
        logic [31:0] ds;
        logic [31:0] dt;
        logic [5:0]  dd;
        logic [15:0] imm;
        logic [5:0]  exp_addr;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic src, input logic [5:0] ope, input logic [31:0] ds,
                         input logic [31:0] dt, input logic [5:0] dd, input logic [15:0] imm);
        if (!src) begin
            req0_valid = 1'b1; req0_ope = ope; req0_ds_val = ds;
            req0_dt_val = dt; req0_dd = dd; req0_imm = imm;
        end else begin
            req1_valid = 1'b1; req1_ope = ope; req1_ds_val = ds;
            req1_dt_val = dt; req1_dd = dd; req1_imm = imm;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc, acc, got, rc;
        vecs[0] = '{1'b0, OP_ADD,  32'd5,          32'd7, 6'd3,  16'h0000, 6'd3,  32'd12};
        vecs[1] = '{1'b1, OP_SRA,  32'h8000_0000,  32'd4, 6'd7,  16'h0000, 6'd7,  32'h0800_0000};
        vecs[2] = '{1'b0, OP_LUI,  32'h0000_5678,  32'd0, 6'd9,  16'h1234, 6'd9,  32'h1234_5678};
        vecs[3] = '{1'b1, OP_BAD,  32'd1,          32'd2, 6'd12, 16'h0000, 6'd0,  32'd0};
        vecs[4] = '{1'b1, OP_ADDI, 32'd10,         32'd0, 6'd2,  16'hFFFF, 6'd2,  32'd9};
        vecs[5] = '{1'b0, OP_SUB,  32'd3,          32'd5, 6'd63, 16'h0000, 6'd63, 32'hFFFF_FFFE};

        // Reset state, with req0 offering an op while reset is held
        tick();
        drive(1'b0, OP_ADD, 32'd1, 32'd1, 6'd1, 16'd0);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_alu_ope", alu_ope, 0);
        chk("rst_alu_ds", alu_ds_val, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_val", res_val, 0);
        chk("rst_res_addr", res_addr, 0);
        req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Reset with three ops in flight
        res_ready = 1'b1;
        drive(1'b0, OP_ADD, 32'd1, 32'd1, 6'd5, 16'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("midrst_accept", req0_ready, 1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_alu_ope", alu_ope, 0);
        chk("midrst_alu_dd", alu_dd, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_addr", res_addr, 0);
        chk("midrst_req0_ready", req0_ready, 0);
        tick();
        req0_valid = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_stale", res_valid, 0);
        end

        // Single ops from the vector table
        for (int i = 0; i < 6; i++) begin
            res_ready = 1'b1;
            drive(vecs[i].src, vecs[i].ope, vecs[i].ds, vecs[i].dt, vecs[i].dd, vecs[i].imm);
            #1;
            chk($sformatf("v%0d_ready", i), vecs[i].src ? req1_ready : req0_ready, 1);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk($sformatf("v%0d_alu_ope", i), alu_ope, vecs[i].ope);
            cyc = 1;
            while (!res_valid && cyc < 8) begin
                tick();
                cyc++;
            end
            chk($sformatf("v%0d_latency", i), cyc, 3);
            chk($sformatf("v%0d_addr", i), res_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_val", i), res_val, vecs[i].exp_val);
            chk($sformatf("v%0d_src", i), res_src, vecs[i].src);
            tick();
            chk($sformatf("v%0d_popped", i), res_valid, 0);
            chk($sformatf("v%0d_idle_ope", i), alu_ope, 0);
        end

        // Both requesters valid every cycle: grants alternate starting with req0
        do_reset();
        res_ready = 1'b1;
        rc = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin
                drive(1'b0, OP_ADD, k, 32'd0, 6'd10, 16'd0);
                drive(1'b1, OP_ADD, k, 32'd0, 6'd20, 16'd0);
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (k < 6) begin
                chk($sformatf("rr_req0_ready_%0d", k), req0_ready, (k % 2 == 0));
                chk($sformatf("rr_req1_ready_%0d", k), req1_ready, (k % 2 == 1));
            end
            if (res_valid) begin
                chk($sformatf("rr_src_%0d", rc), res_src, rc % 2);
                chk($sformatf("rr_val_%0d", rc), res_val, rc);
                chk($sformatf("rr_addr_%0d", rc), res_addr, (rc % 2) ? 20 : 10);
                rc++;
            end
            tick();
        end
        chk("rr_result_count", rc, 6);

        // Back-pressure: credit stops req0 after four accepts, nothing is lost
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, OP_ADDI, acc, 32'd0, 6'd4, 16'd1);
            #1;
            if (req0_ready) begin
                tick();
                acc++;
            end else begin
                tick();
            end
        end
        chk("bp_accepted", acc, 4);
        #1;
        chk("bp_ready_low", req0_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_head_stable", res_val, 1);
        chk("bp_head_addr", res_addr, 4);
        req0_valid = 1'b0;
        res_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (res_valid) begin
                chk($sformatf("bp_val_%0d", got), res_val, got + 1);
                got++;
            end
            tick();
        end
        chk("bp_drained", got, 4);
        req0_valid = 1'b1;
        #1;
        chk("bp_ready_back", req0_ready, 1);
        req0_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
